alu_md_unit: RTL

- Parametrised successor to the single-cycle ALU, for the pipelined datapath.
- Contains a combinational integer ALU and a sequential multiply/divide engine.
- The engine holds HI/LO registers.
- Sits in EX stage; `busy` feeds the hazard unit to stall later MD/MFHI/MFLO instructions.

---
 rtl/alu_md_pkg.sv | 33 +++
 rtl/md_div_iter.sv | 90 +++++++++
 rtl/alu_md_unit.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/alu_md_pkg.sv
// alu_md_pkg: shared encodings for the EX-stage ALU and multiply/divide engine.
//   - alu_op codes (4 bit). ADD/SUB/OR keep the low bits of the old 3-bit codes.
//   - md_op codes (3 bit). Codes 6 and 7 are unused and leave the engine untouched.
//   - md_state_t: engine FSM state encoding.
package alu_md_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_OR   = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } md_state_t;

endpackage

// File: rtl/md_div_iter.sv
// md_div_iter: iterative restoring divider, one quotient bit per cycle.
//   clk, reset     : clock, asynchronous active-low reset
//   start          : load operands and run WIDTH iterations (first one on the start edge)
//   is_signed      : treat dividend/divisor as two's complement
//   dividend       : numerator, sampled on start
//   divisor        : denominator, sampled on start
//   done           : level, high once the result is complete; cleared by the next start
//   quotient       : truncates toward zero; all ones when divisor == 0
//   remainder      : sign of the dividend; equals the dividend when divisor == 0
// Handshake: start is a single-cycle request; done rises WIDTH-1 edges after the
// start edge and stays high, with quotient/remainder stable, until the next start.
module md_div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_r, quo_r, dvs_r;
    logic             neg_q_r, neg_r_r, run_r, done_r;
    logic [CW-1:0]    cnt_r;

    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] rem_in, quo_in, dvs_in;
    logic [WIDTH:0]   trial;
    logic             ge;
    logic [WIDTH-1:0] step_rem, step_quo;

    // Work on magnitudes; signs are restored on the way out.
    assign mag_a = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    assign mag_b = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

    // The start edge already performs the first iteration on the fresh operands,
    // so the final bit is formed WIDTH-1 edges later.
    assign rem_in = start ? '0    : rem_r;
    assign quo_in = start ? mag_a : quo_r;
    assign dvs_in = start ? mag_b : dvs_r;

    assign trial    = {rem_in, quo_in[WIDTH-1]};
    assign ge       = (trial >= {1'b0, dvs_in});
    // The restored remainder is always below the divisor, so the low WIDTH bits
    // of the difference are exact.
    assign step_rem = ge ? (trial[WIDTH-1:0] - dvs_in) : trial[WIDTH-1:0];
    assign step_quo = {quo_in[WIDTH-2:0], ge};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem_r   <= '0;
            quo_r   <= '0;
            dvs_r   <= '0;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
            run_r   <= 1'b0;
            done_r  <= 1'b0;
            cnt_r   <= '0;
        end else if (start) begin
            rem_r   <= step_rem;
            quo_r   <= step_quo;
            dvs_r   <= mag_b;
            // A zero divisor yields raw all-ones; it must not be negated.
            neg_q_r <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]) && (divisor != '0);
            neg_r_r <= is_signed && dividend[WIDTH-1];
            cnt_r   <= CW'(WIDTH - 1);
            run_r   <= 1'b1;
            done_r  <= 1'b0;
        end else if (run_r) begin
            rem_r <= step_rem;
            quo_r <= step_quo;
            cnt_r <= cnt_r - 1'b1;
            if (cnt_r == CW'(1)) begin
                run_r  <= 1'b0;
                done_r <= 1'b1;
            end
        end
    end

    assign done      = done_r;
    assign quotient  = neg_q_r ? -quo_r : quo_r;
    assign remainder = neg_r_r ? -rem_r : rem_r;

endmodule

// File: rtl/alu_md_unit.sv
// alu_md_unit: EX-stage combinational ALU plus sequential multiply/divide engine
// holding the HI/LO registers.
//   clk, reset : clock, asynchronous active-low reset
//   a, b       : operands (rs, rt/imm)
//   alu_op     : ALU operation select; alu_out is combinational
//   zero       : a == b, independent of alu_op
//   ovf        : signed overflow of ADD/SUB (only when ALU_OVF_EN is defined)
//   md_op      : MD operation select, md_start launches it when busy is low
//   busy       : engine occupied by MULT/MULTU/DIV/DIVU
//   md_done    : one-cycle pulse when HI/LO were written by a multiply/divide
//   hi, lo     : HI/LO registers; they keep their old value while busy
//   dbg_state  : current engine FSM state (md_state_t encoding)
// Build option: define ALU_OVF_EN to add the ovf output and its logic.
// md handshake: a start is accepted on a rising edge where md_start=1 and busy=0;
// operands and op are captured on that edge. Starts while busy are dropped.
// DIV_LAT must be at least WIDTH because the divider needs WIDTH iterations.
module alu_md_unit
    import alu_md_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_op,
    output logic [WIDTH-1:0] alu_out,
    output logic             zero,
`ifdef ALU_OVF_EN
    output logic             ovf,
`endif
    input  logic [2:0]       md_op,
    input  logic             md_start,
    output logic             busy,
    output logic             md_done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       dbg_state
);

    localparam int S       = $clog2(WIDTH);
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    // ---------------------------------------------------------------- ALU
    logic [S-1:0]     shamt;
    logic [WIDTH-1:0] sum, dif;

    assign shamt = a[S-1:0];
    assign sum   = a + b;
    assign dif   = a - b;
    assign zero  = (a == b);

    always_comb begin
        alu_out = '0;
        case (alu_op)
            ALU_ADD:  alu_out = sum;
            ALU_SUB:  alu_out = dif;
            ALU_OR:   alu_out = a | b;
            ALU_AND:  alu_out = a & b;
            ALU_XOR:  alu_out = a ^ b;
            ALU_NOR:  alu_out = ~(a | b);
            ALU_SLT:  alu_out = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: alu_out = {{(WIDTH-1){1'b0}}, (a < b)};
            ALU_SLL:  alu_out = b << shamt;
            ALU_SRL:  alu_out = b >> shamt;
            ALU_SRA:  alu_out = $signed(b) >>> shamt;
            ALU_LUI:  alu_out = b << (WIDTH / 2);
            default:  alu_out = '0;
        endcase
    end

`ifdef ALU_OVF_EN
    // Overflow: operands of the effective addition share a sign that the result lacks.
    always_comb begin
        ovf = 1'b0;
        if (alu_op == ALU_ADD)
            ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        else if (alu_op == ALU_SUB)
            ovf = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
    end
`endif

    // ---------------------------------------------------------- MD engine
    md_state_t          state;
    logic [CW-1:0]      cnt_r;
    logic [2*WIDTH-1:0] prod_r;
    logic               busy_r, done_r;
    logic [WIDTH-1:0]   hi_r, lo_r;

    logic               idle_start;
    logic               mul_signed;
    logic [2*WIDTH-1:0] ext_a, ext_b, mul_prod;
    logic               div_start, div_signed, div_done;
    logic [WIDTH-1:0]   div_quo, div_rem;

    assign idle_start = (state == ST_IDLE) && md_start;

    // One multiplier for both flavours: the low 2*WIDTH bits of the product of the
    // sign- or zero-extended operands are the signed or unsigned product.
    assign mul_signed = (md_op == MD_MULT);
    assign ext_a      = mul_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    assign ext_b      = mul_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    assign mul_prod   = ext_a * ext_b;

    assign div_start  = idle_start && ((md_op == MD_DIV) || (md_op == MD_DIVU));
    assign div_signed = (md_op == MD_DIV);

    md_div_iter #(
        .WIDTH (WIDTH)
    ) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .is_signed (div_signed),
        .dividend  (a),
        .divisor   (b),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // The product is registered on the accepting edge and held for the rest of
    // the MUL_LAT window; HI/LO only change on the final edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            cnt_r  <= '0;
            prod_r <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (md_start) begin
                        case (md_op)
                            MD_MULT, MD_MULTU: begin
                                prod_r <= mul_prod;
                                cnt_r  <= CW'(MUL_LAT - 1);
                                busy_r <= 1'b1;
                                state  <= ST_MUL;
                            end
                            MD_DIV, MD_DIVU: begin
                                cnt_r  <= CW'(DIV_LAT - 1);
                                busy_r <= 1'b1;
                                state  <= ST_DIV;
                            end
                            MD_MTHI: hi_r <= a;
                            MD_MTLO: lo_r <= a;
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    if (cnt_r == '0) begin
                        {hi_r, lo_r} <= prod_r;
                        busy_r       <= 1'b0;
                        done_r       <= 1'b1;
                        state        <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r - 1'b1;
                    end
                end
                ST_DIV: begin
                    if (cnt_r == '0) begin
                        if (div_done) begin
                            hi_r <= div_rem;
                            lo_r <= div_quo;
                        end
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = busy_r;
    assign md_done   = done_r;
    assign hi        = hi_r;
    assign lo        = lo_r;
    assign dbg_state = state;

endmodule
